// File: rtl/axi4_slave_mem.sv
// rtl/axi4_slave_mem.sv - AXI4 32-bit memory responder with independent read/write FSMs and backdoor port
// Optional random ready stalls: define AXI_SLV_MEM_BACKPRESSURE_EN.
`timescale 1ns/1ps
module axi4_slave_mem #(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          ID_W      = 1,
    parameter logic [31:0] FILL      = 32'hFFFFFFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [ID_W-1:0] s_axi_awid,
    input  logic [31:0]     s_axi_awaddr,
    input  logic [7:0]      s_axi_awlen,
    input  logic [2:0]      s_axi_awsize,
    input  logic [1:0]      s_axi_awburst,
    input  logic            s_axi_awvalid,
    output logic            s_axi_awready,
    input  logic [31:0]     s_axi_wdata,
    input  logic [3:0]      s_axi_wstrb,
    input  logic            s_axi_wlast,
    input  logic            s_axi_wvalid,
    output logic            s_axi_wready,
    output logic [ID_W-1:0] s_axi_bid,
    output logic [1:0]      s_axi_bresp,
    output logic            s_axi_bvalid,
    input  logic            s_axi_bready,
    input  logic [ID_W-1:0] s_axi_arid,
    input  logic [31:0]     s_axi_araddr,
    input  logic [7:0]      s_axi_arlen,
    input  logic [2:0]      s_axi_arsize,
    input  logic [1:0]      s_axi_arburst,
    input  logic            s_axi_arvalid,
    output logic            s_axi_arready,
    output logic [ID_W-1:0] s_axi_rid,
    output logic [31:0]     s_axi_rdata,
    output logic [1:0]      s_axi_rresp,
    output logic            s_axi_rlast,
    output logic            s_axi_rvalid,
    input  logic            s_axi_rready,
    input  logic            bd_en,
    input  logic            bd_we,
    input  logic [31:0]     bd_addr,
    input  logic [31:0]     bd_wdata,
    input  logic [3:0]      bd_wstrb,
    output logic [31:0]     bd_rdata
);
    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [31:0] WIN_BYTES = 32'(4 * MEM_WORDS);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    // Only FIXED (00) and INCR (01) with size <= 4 bytes inside the window are serviced.
    function automatic logic beat_err(input logic [31:0] addr, input logic [2:0] size,
                                      input logic [1:0] burst);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return (burst[1] == 1'b1) || (size > 3'd2) || (off >= WIN_BYTES);
    endfunction

    function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [2:0] size,
                                              input logic [1:0] burst);
        return (burst == 2'b00) ? addr : addr + (32'd1 << size);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return IDX_W'(off >> 2);
    endfunction

    logic [31:0] r_mem [MEM_WORDS] = '{default: FILL};

    logic w_bp_aw, w_bp_w, w_bp_ar;
`ifdef AXI_SLV_MEM_BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_lfsr <= 16'hACE1;
        else      r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_bp_aw = r_lfsr[0];
    assign w_bp_w  = r_lfsr[5];
    assign w_bp_ar = r_lfsr[10];
`else
    assign w_bp_aw = 1'b1;
    assign w_bp_w  = 1'b1;
    assign w_bp_ar = 1'b1;
`endif

    wstate_t         r_wstate;
    logic            r_awready, r_bvalid, r_werr;
    logic [ID_W-1:0] r_awid;
    logic [31:0]     r_awaddr;
    logic [7:0]      r_awlen, r_wcnt;
    logic [2:0]      r_awsize;
    logic [1:0]      r_awburst, r_bresp;

    logic w_aw_hs, w_w_hs, w_wbeat_err, w_wlast_exp, w_bd_wr;
    assign w_bd_wr       = bd_en & bd_we;
    assign s_axi_awready = r_awready & w_bp_aw;
    assign s_axi_wready  = (r_wstate == W_DATA) & ~w_bd_wr & w_bp_w;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_bid     = r_awid;
    assign w_aw_hs       = s_axi_awvalid & s_axi_awready;
    assign w_w_hs        = s_axi_wvalid & s_axi_wready;
    assign w_wbeat_err   = beat_err(r_awaddr, r_awsize, r_awburst);
    assign w_wlast_exp   = (r_wcnt == r_awlen);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= 2'b00;
            r_werr    <= 1'b0;
            r_awid    <= '0;
            r_awaddr  <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_awid    <= s_axi_awid;
                        r_awaddr  <= s_axi_awaddr;
                        r_awlen   <= s_axi_awlen;
                        r_awsize  <= s_axi_awsize;
                        r_awburst <= s_axi_awburst;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wstate  <= W_DATA;
                    end else begin
                        r_awready <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_awaddr <= next_addr(r_awaddr, r_awsize, r_awburst);
                        r_wcnt   <= r_wcnt + 8'd1;
                        // Beat count comes from awlen; a disagreeing wlast only taints the response.
                        if (w_wlast_exp) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_wbeat_err | ~s_axi_wlast) ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end else begin
                            r_werr <= r_werr | w_wbeat_err | s_axi_wlast;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    rstate_t         r_rstate;
    logic            r_arready, r_rvalid, r_rlast;
    logic [ID_W-1:0] r_rid;
    logic [31:0]     r_raddr, r_rdata;
    logic [7:0]      r_arlen, r_rcnt;
    logic [2:0]      r_arsize;
    logic [1:0]      r_arburst, r_rresp;

    logic        w_ar_hs, w_rd_err;
    logic [31:0] w_rd_addr, w_rd_data;
    logic [2:0]  w_rd_size;
    logic [1:0]  w_rd_burst;
    assign s_axi_arready = r_arready & w_bp_ar;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rid     = r_rid;
    assign w_ar_hs       = s_axi_arvalid & s_axi_arready;

    // Address of the beat that gets loaded into the R output register at the next edge.
    assign w_rd_addr  = (r_rstate == R_IDLE) ? s_axi_araddr : next_addr(r_raddr, r_arsize, r_arburst);
    assign w_rd_size  = (r_rstate == R_IDLE) ? s_axi_arsize : r_arsize;
    assign w_rd_burst = (r_rstate == R_IDLE) ? s_axi_arburst : r_arburst;
    assign w_rd_err   = beat_err(w_rd_addr, w_rd_size, w_rd_burst);
    assign w_rd_data  = w_rd_err ? FILL : r_mem[word_idx(w_rd_addr)];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_rid     <= s_axi_arid;
                        r_raddr   <= s_axi_araddr;
                        r_arlen   <= s_axi_arlen;
                        r_arsize  <= s_axi_arsize;
                        r_arburst <= s_axi_arburst;
                        r_rcnt    <= '0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_err ? 2'b10 : 2'b00;
                        r_rlast   <= (s_axi_arlen == 8'd0);
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_raddr <= w_rd_addr;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rdata <= w_rd_data;
                            r_rresp <= w_rd_err ? 2'b10 : 2'b00;
                            r_rlast <= ((r_rcnt + 8'd1) == r_arlen);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    logic w_bd_oor;
    assign w_bd_oor = ((bd_addr - BASE_ADDR) >= WIN_BYTES);

    // Storage has no reset so that a reset mid-burst keeps what was already written.
    always_ff @(posedge clk) begin
        if (w_bd_wr) begin
            if (!w_bd_oor) begin
                for (int b = 0; b < 4; b++)
                    if (bd_wstrb[b]) r_mem[word_idx(bd_addr)][8*b +: 8] <= bd_wdata[8*b +: 8];
            end
        end else if (w_w_hs && !w_wbeat_err) begin
            for (int b = 0; b < 4; b++)
                if (s_axi_wstrb[b]) r_mem[word_idx(r_awaddr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
        end
    end

    logic [31:0] r_bd_rdata;
    assign bd_rdata = r_bd_rdata;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_bd_rdata <= '0;
        else if (bd_en && !bd_we)   r_bd_rdata <= w_bd_oor ? FILL : r_mem[word_idx(bd_addr)];
    end
endmodule

// File: doc/axi4_slave_mem.md
# axi4_slave_mem

Synthesizable AXI4 memory-mapped responder with a 32-bit data bus. It is the slave end of the AXI master interface exported by Bambu-generated accelerators such as mmult. It replaces the vendor VIP slave memory model in vendor-neutral simulation and on-FPGA bring-up. A backdoor port lets the bench preload and check memory.

## Interface
- MEM_WORDS, 1024: depth of the 32-bit word array (power of two).
- BASE_ADDR, 32'h0: byte address of word 0. The window is [BASE_ADDR, BASE_ADDR+4*MEM_WORDS).
- ID_W, 1: width of the AXI ID fields.
- FILL, 32'hFFFFFFFF: initial content of every word. It is also the rdata value on error beats.

Ports:
- clk  in  1  clock, all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_W/32/8/3/2  write address channel.
- s_axi_awvalid in 1; s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast  in  32/4/1  write data channel.
- s_axi_wvalid in 1; s_axi_wready out 1  W handshake.
- s_axi_bid/bresp  out  ID_W/2  write response.
- s_axi_bvalid out 1; s_axi_bready in 1  B handshake.
- s_axi_arid/araddr/arlen/arsize/arburst  in  ID_W/32/8/3/2  read address channel.
- s_axi_arvalid in 1; s_axi_arready out 1  AR handshake.
- s_axi_rid/rdata/rresp/rlast  out  ID_W/32/2/1  read data channel.
- s_axi_rvalid out 1; s_axi_rready in 1  R handshake.
- bd_en/bd_we/bd_addr/bd_wdata/bd_wstrb  in  1/1/32/32/4  backdoor access using a byte address.
- bd_rdata  out  32  backdoor read data, registered.

## Operation
- The write path and the read path are independent FSMs. Each has one outstanding transaction. No ordering is enforced between the two paths.
- Write FSM: W_IDLE → W_DATA → W_RESP → W_IDLE.
  - W_IDLE: awready=1. On the AW handshake, capture the address fields and go to W_DATA.
  - W_DATA: wready=1, except in cycles where bd_en&bd_we=1.
    - Each W handshake writes the enabled byte lanes per wstrb, then advances the address.
    - After awlen+1 beats, go to W_RESP.
  - W_RESP: bvalid=1 with bid equal to the captured awid. Hold until bready=1, then return to W_IDLE.
- Read FSM: R_IDLE → R_DATA → R_IDLE.
  - R_IDLE: arready=1. On the AR handshake, capture the address fields and go to R_DATA.
  - R_DATA: rvalid=1, and rlast=1 on beat arlen. The beat advances on rready=1. Return to R_IDLE after the last handshake.
- Address update per beat:
  - INCR: addr += 1<<size.
  - FIXED: address unchanged.
  - Word index is (addr-BASE_ADDR)>>2.
- Error conditions:
  - Any beat outside the window, burst=WRAP or reserved, or size>2 → SLVERR (2'b10).
  - Writes: error beats are dropped.
  - Reads: error beats return FILL with rresp=SLVERR.
  - bresp=SLVERR if any beat in the burst errored, otherwise OKAY.
- wlast mismatch: beat counting follows awlen only. A wlast value that disagrees with the beat count forces bresp=SLVERR. The data is still written.
- Backdoor access:
  - bd_en&bd_we writes per bd_wstrb and takes priority over an AXI write in that cycle.
  - bd_en&!bd_we loads bd_rdata on the next edge.
  - Out-of-window backdoor addresses are ignored, and bd_rdata=FILL.
- Memory content is initialized to FILL and is not affected by rst.

## Timing
- Reset state: both FSMs idle, awready=arready=wready=bvalid=rvalid=rlast=0, bresp=rresp=0, rdata=0, bd_rdata=0.
- awready and arready rise the first cycle after rst is released.
- Read latency: AR handshake at edge N → rvalid at N+1. Back-to-back beats run at 1/cycle while rready=1. rdata/rresp/rlast hold stable while rvalid&!rready.
- Write: AW handshake at N → wready from N+1. Last W handshake at M → bvalid at M+1. The next awready comes one cycle after the B handshake.
- A same-cycle AXI write and R beat to the same word: the R beat returns the old data.
- rst asserted mid-burst: the burst is abandoned, no B or R completion is produced, and already-written beats stay in memory.

## Configuration
- AXI_SLV_MEM_BACKPRESSURE_EN:
  - Defined: a 16-bit LFSR (seed 16'hACE1, advancing every cycle) gates awready, wready and arready. Each is forced low when its LFSR tap bit is 0, giving roughly 50% random stalls.
  - Undefined: no backpressure, exactly as described above.

## Test plan
- Backdoor write 0x11223344 @0x40, then AXI read of 1 beat at 0x40 → rdata=0x11223344, rresp=OKAY, rlast=1, rvalid one cycle after the AR handshake.
- AXI INCR write, awlen=3, addr 0x100, data 1..4, wstrb=F → bresp=OKAY; backdoor reads of 0x100..0x10C return 1..4.
- Single-beat write to 0x200 with wstrb=4'b0010, data 0xAABBCCDD → word reads 0xFFFFCCFF.
- Read at BASE_ADDR+4*MEM_WORDS, arlen=1 → two beats rdata=FILL, rresp=SLVERR; write to the same address → bresp=SLVERR and memory unchanged.
- INCR read, arlen=7, with rready toggling 1/0 → 8 beats in order, rlast only on beat 7, data held stable during stalls.
- rst pulsed low during beat 2 of an awlen=7 write → no bvalid, awready=1 after release, beats 0-1 present in memory.
